usart_baud_gen: RTL and testbench

- Parametrised successor to the USART clock generator.
- Produces single-cycle tick enables in the CPUClk domain for the USART transmitter and receiver.
- Async mode: oversampled receive ticks and bit-rate transmit ticks, from a programmable integer+fractional divisor.
- Sync mode: serial clock master (internal source) or slave (synchronised ExClk), with selectable clock polarity.

---
 rtl/usart_baud_gen.sv | 185 ++++++++++++++++++
 tb/tb_usart_baud_gen.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usart_baud_gen.sv
// usart_baud_gen
//   Tick generator for a USART, entirely in the CPUClk domain.
//   Async mode : fractional-N prescaler drives RxTick (OVS x baud); every
//                OVS-th RxTick also raises TxTick (baud).
//   Sync master: the prescaler toggles SClk; ticks mark launch/sample edges.
//   Sync slave : ExClk is synchronised, edge-detected and mapped to ticks.
//
// Ports
//   CPUClk  in   system clock (rising edge)
//   Reset   in   asynchronous active-high reset
//   Enable  in   1 = run, 0 = hold counters / suppress ticks
//   Load    in   strobe: latch Mode/ClkSrc/ClkPol/DivInt/DivFrac, restart
//   Mode    in   0 = async, 1 = sync
//   ClkSrc  in   sync only: 0 = internal (master), 1 = ExClk (slave)
//   ClkPol  in   sync SClk idle level and edge mapping
//   DivInt  in   integer divisor, 0 halts the prescaler
//   DivFrac in   fractional divisor, in units of 1/2^FRAC_W
//   ExClk   in   external serial clock (asynchronous)
//   RxTick  out  sample tick
//   TxTick  out  launch tick
//   SClk    out  serial clock
module usart_baud_gen #(
  parameter int DIV_W       = 16,
  parameter int FRAC_W      = 4,
  parameter int OVS         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CPUClk,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              Load,
  input  logic              Mode,
  input  logic              ClkSrc,
  input  logic              ClkPol,
  input  logic [DIV_W-1:0]  DivInt,
  input  logic [FRAC_W-1:0] DivFrac,
  input  logic              ExClk,
  output logic              RxTick,
  output logic              TxTick,
  output logic              SClk
);

  localparam int OVS_W = $clog2(OVS);
  localparam logic [DIV_W:0] ONE_P = (DIV_W+1)'(1);

  // Latched configuration
  logic              mode_q, mode_d;
  logic              src_q, src_d;
  logic              pol_q, pol_d;
  logic [DIV_W-1:0]  div_int_q, div_int_d;
  logic [FRAC_W-1:0] div_frac_q, div_frac_d;

  // Prescaler / fractional accumulator / oversampling counter
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [OVS_W-1:0]  ovs_q, ovs_d;

  // Master SClk, ExClk synchroniser and edge-detect register
  logic                   sclk_q, sclk_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;

  logic rx_q, rx_d;
  logic tx_q, tx_d;

  logic              slave;
  logic              presc_run;
  logic              expire;
  logic [DIV_W:0]    period;
  logic [FRAC_W:0]   frac_sum;
  logic              sync_lvl;
  logic              slave_edge;
  logic              sclk_new;

  assign slave      = mode_q & src_q;
  // Current period stretches by one cycle when the previous accumulate carried.
  assign period     = {1'b0, div_int_q} + {{DIV_W{1'b0}}, carry_q};
  assign presc_run  = Enable && (div_int_q != '0) && !slave;
  assign expire     = presc_run && ({1'b0, cnt_q} == (period - ONE_P));
  assign frac_sum   = {1'b0, acc_q} + {1'b0, div_frac_q};
  assign sync_lvl   = sync_q[SYNC_STAGES-1];
  assign slave_edge = sync_lvl ^ edge_q;
  assign sclk_new   = ~sclk_q;

  always_comb begin
    mode_d     = mode_q;
    src_d      = src_q;
    pol_d      = pol_q;
    div_int_d  = div_int_q;
    div_frac_d = div_frac_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    ovs_d      = ovs_q;
    sclk_d     = sclk_q;
    rx_d       = 1'b0;
    tx_d       = 1'b0;
    // The synchroniser free-runs regardless of Load/Enable.
    sync_d     = {sync_q[SYNC_STAGES-2:0], ExClk};
    edge_d     = sync_lvl;

    if (Load) begin
      // Load takes priority over any expiry or slave edge this cycle.
      mode_d     = Mode;
      src_d      = ClkSrc;
      pol_d      = ClkPol;
      div_int_d  = DivInt;
      div_frac_d = DivFrac;
      cnt_d      = '0;
      acc_d      = '0;
      carry_d    = 1'b0;
      ovs_d      = '0;
      sclk_d     = Mode ? ClkPol : 1'b0;
    end else begin
      if (expire) begin
        cnt_d   = '0;
        acc_d   = frac_sum[FRAC_W-1:0];
        carry_d = frac_sum[FRAC_W];
        if (!mode_q) begin
          rx_d = 1'b1;
          if (ovs_q == OVS_W'(OVS-1)) begin
            tx_d  = 1'b1;
            ovs_d = '0;
          end else begin
            ovs_d = ovs_q + OVS_W'(1);
          end
        end else begin
          // Leaving the idle level is the sample edge, returning is launch.
          sclk_d = sclk_new;
          if (sclk_new != pol_q) rx_d = 1'b1;
          else                   tx_d = 1'b1;
        end
      end else if (presc_run) begin
        cnt_d = cnt_q + DIV_W'(1);
      end

      if (mode_q && !src_q && !Enable) sclk_d = pol_q;

      if (slave && Enable && slave_edge) begin
        if (sync_lvl != pol_q) rx_d = 1'b1;
        else                   tx_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CPUClk or posedge Reset) begin
    if (Reset) begin
      mode_q     <= 1'b0;
      src_q      <= 1'b0;
      pol_q      <= 1'b0;
      div_int_q  <= '0;
      div_frac_q <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      ovs_q      <= '0;
      sclk_q     <= 1'b0;
      sync_q     <= '0;
      edge_q     <= 1'b0;
      rx_q       <= 1'b0;
      tx_q       <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      src_q      <= src_d;
      pol_q      <= pol_d;
      div_int_q  <= div_int_d;
      div_frac_q <= div_frac_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      ovs_q      <= ovs_d;
      sclk_q     <= sclk_d;
      sync_q     <= sync_d;
      edge_q     <= edge_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
    end
  end

  assign RxTick = rx_q;
  assign TxTick = tx_q;
  assign SClk   = mode_q ? (src_q ? sync_lvl : sclk_q) : 1'b0;

endmodule

// File: tb/tb_usart_baud_gen.sv
module tb_usart_baud_gen;

  logic        CPUClk = 1'b0;
  logic        Reset;
  logic        Enable;
  logic        Load;
  logic        Mode;
  logic        ClkSrc;
  logic        ClkPol;
  logic [15:0] DivInt;
  logic [3:0]  DivFrac;
  logic        ExClk;
  logic        RxTick;
  logic        TxTick;
  logic        SClk;

  int total = 0;
  int bad   = 0;

  usart_baud_gen #(
    .DIV_W(16), .FRAC_W(4), .OVS(16), .SYNC_STAGES(2)
  ) dut (
    .CPUClk (CPUClk),
    .Reset  (Reset),
    .Enable (Enable),
    .Load   (Load),
    .Mode   (Mode),
    .ClkSrc (ClkSrc),
    .ClkPol (ClkPol),
    .DivInt (DivInt),
    .DivFrac(DivFrac),
    .ExClk  (ExClk),
    .RxTick (RxTick),
    .TxTick (TxTick),
    .SClk   (SClk)
  );

  always #5 CPUClk = ~CPUClk;

  typedef struct {
    logic mode;
    logic pol;
    int   div;
    int   frac;
    int   cycles;
    int   exp_rx;
    int   exp_tx;
    int   exp_first;
    int   exp_idle;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic step();
    @(posedge CPUClk);
    #1;
  endtask

  task automatic do_load(input logic m, input logic s, input logic p, input int d, input int f);
    Mode    = m;
    ClkSrc  = s;
    ClkPol  = p;
    DivInt  = 16'(d);
    DivFrac = 4'(f);
    Load    = 1'b1;
    step();
    Load    = 1'b0;
  endtask

  // Edge count (enabled cycles after Load) at which the n-th prescaler expiry occurs.
  function automatic int tn(input int n, input int d, input int f);
    return n * d + (((n - 1) * f) / 16);
  endfunction

  initial begin
    int rxc, txc, first, both;
    int ecount, nn;
    logic lvl, en, rx_e, tx_e, a, b, m, p;
    int d, f;
    logic hist[$];

    Reset = 1'b1; Enable = 1'b0; Load = 1'b0; Mode = 1'b0; ClkSrc = 1'b0;
    ClkPol = 1'b0; DivInt = '0; DivFrac = '0; ExClk = 1'b0;

    // --- reset state ---
    step(); step();
    check("reset_rx", int'(RxTick), 0);
    check("reset_tx", int'(TxTick), 0);
    check("reset_sclk", int'(SClk), 0);
    Reset = 1'b0;
    Enable = 1'b1;
    rxc = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      rxc += int'(RxTick) + int'(TxTick);
    end
    check("post_reset_idle_ticks", rxc, 0);
    $display("reset: outputs idle, no ticks before Load");

    // --- table-driven vectors ---
    tbl[0] = '{1'b0, 1'b0, 4, 0,   64, 16, 1, 4, 0};
    tbl[1] = '{1'b0, 1'b0, 3, 8,   56, 16, 1, 3, 0};
    tbl[2] = '{1'b0, 1'b0, 0, 15, 1000, 0, 0, 0, 0};
    tbl[3] = '{1'b0, 1'b0, 1, 0,   20, 20, 1, 1, 0};
    tbl[4] = '{1'b1, 1'b0, 5, 0,   40,  4, 4, 5, 0};
    tbl[5] = '{1'b1, 1'b1, 5, 0,   40,  4, 4, 5, 1};
    tbl[6] = '{1'b0, 1'b0, 2, 15,  30, 10, 0, 2, 0};
    for (int i = 0; i < 7; i++) begin
      Enable = 1'b1;
      do_load(tbl[i].mode, 1'b0, tbl[i].pol, tbl[i].div, tbl[i].frac);
      check($sformatf("vec%0d_load_sclk", i), int'(SClk), tbl[i].exp_idle);
      check($sformatf("vec%0d_load_rx", i), int'(RxTick), 0);
      rxc = 0; txc = 0; first = 0; both = 0;
      for (int c = 1; c <= tbl[i].cycles; c++) begin
        step();
        if (RxTick) begin
          rxc++;
          if (first == 0) first = c;
        end
        if (TxTick) txc++;
        if (RxTick && TxTick && tbl[i].mode) both++;
      end
      check($sformatf("vec%0d_rx_count", i), rxc, tbl[i].exp_rx);
      check($sformatf("vec%0d_tx_count", i), txc, tbl[i].exp_tx);
      check($sformatf("vec%0d_first_rx", i), first, tbl[i].exp_first);
      check($sformatf("vec%0d_both_high", i), both, 0);
      $display("vec %0d: mode=%0d pol=%0d div=%0d frac=%0d rx=%0d tx=%0d first=%0d",
               i, tbl[i].mode, tbl[i].pol, tbl[i].div, tbl[i].frac, rxc, txc, first);
    end

    // --- Load coinciding with an expiry: no tick that cycle, restart ---
    Enable = 1'b1;
    do_load(1'b0, 1'b0, 1'b0, 4, 0);
    step(); step(); step();
    do_load(1'b0, 1'b0, 1'b0, 4, 0);
    check("coincide_load_rx", int'(RxTick), 0);
    rxc = 0;
    for (int c = 1; c <= 3; c++) begin
      step();
      rxc += int'(RxTick);
    end
    check("coincide_gap_rx", rxc, 0);
    step();
    check("coincide_next_rx", int'(RxTick), 1);
    $display("coincide: load on expiry suppressed tick, next tick 4 cycles later");

    // --- reload mid-period, then async reset mid-cycle ---
    do_load(1'b0, 1'b0, 1'b0, 10, 0);
    first = 0;
    for (int c = 1; c <= 13; c++) begin
      step();
      if (RxTick && first == 0) first = c;
    end
    check("reload_first_rx_div10", first, 10);
    do_load(1'b0, 1'b0, 1'b0, 6, 0);
    rxc = 0;
    for (int c = 1; c <= 5; c++) begin
      step();
      rxc += int'(RxTick);
    end
    check("reload_gap_rx", rxc, 0);
    step();
    check("reload_rx_at_6", int'(RxTick), 1);
    #2 Reset = 1'b1;
    #1;
    check("async_reset_rx", int'(RxTick), 0);
    check("async_reset_tx", int'(TxTick), 0);
    check("async_reset_sclk", int'(SClk), 0);
    step();
    Reset = 1'b0;
    rxc = 0;
    for (int c = 0; c < 50; c++) begin
      step();
      rxc += int'(RxTick) + int'(TxTick) + int'(SClk);
    end
    check("after_reset_no_activity", rxc, 0);
    $display("reload/reset: tick 6 after reload, reset cleared outputs at once");

    // --- sync slave: history-based model of ExClk ---
    for (int pass = 0; pass < 2; pass++) begin
      p = logic'(pass);
      Enable = 1'b1;
      ExClk = 1'b0;
      do_load(1'b1, 1'b1, p, 7, 3);
      for (int c = 0; c < 4; c++) step();
      hist.delete();
      hist.push_back(1'b0); hist.push_back(1'b0); hist.push_back(1'b0);
      rxc = 0; txc = 0;
      for (int k = 1; k <= 120; k++) begin
        ExClk = logic'((k / 10) % 2);
        en = (pass == 0) ? 1'b1 : logic'($urandom_range(0, 7) != 0);
        Enable = en;
        hist.push_back(ExClk);
        step();
        a = hist[hist.size() - 3];
        b = hist[hist.size() - 4];
        rx_e = en && (a != b) && (a != p);
        tx_e = en && (a != b) && (a == p);
        check($sformatf("slave%0d_k%0d_sclk", pass, k), int'(SClk), int'(hist[hist.size() - 2]));
        check($sformatf("slave%0d_k%0d_rx", pass, k), int'(RxTick), int'(rx_e));
        check($sformatf("slave%0d_k%0d_tx", pass, k), int'(TxTick), int'(tx_e));
        rxc += int'(RxTick);
        txc += int'(TxTick);
      end
      $display("slave pol=%0d: rx=%0d tx=%0d over 120 cycles", p, rxc, txc);
    end
    ExClk = 1'b0;

    // --- randomized async / sync-master against an arithmetic model ---
    for (int s = 0; s < 10; s++) begin
      m = logic'($urandom_range(0, 1));
      p = logic'($urandom_range(0, 1));
      d = int'($urandom_range(1, 6));
      f = int'($urandom_range(0, 15));
      Enable = 1'b1;
      do_load(m, 1'b0, p, d, f);
      lvl = m ? p : 1'b0;
      check($sformatf("rand%0d_idle", s), int'(SClk), int'(lvl));
      ecount = 0; nn = 1; rxc = 0;
      for (int c = 1; c <= 250; c++) begin
        en = logic'($urandom_range(0, 9) != 0);
        Enable = en;
        step();
        rx_e = 1'b0; tx_e = 1'b0;
        if (en) begin
          ecount++;
          if (ecount == tn(nn, d, f)) begin
            if (!m) begin
              rx_e = 1'b1;
              tx_e = (nn % 16) == 0;
            end else begin
              lvl = ~lvl;
              rx_e = (lvl != p);
              tx_e = (lvl == p);
            end
            nn++;
          end
        end else if (m) begin
          lvl = p;
        end
        check($sformatf("rand%0d_c%0d_rx", s, c), int'(RxTick), int'(rx_e));
        check($sformatf("rand%0d_c%0d_tx", s, c), int'(TxTick), int'(tx_e));
        check($sformatf("rand%0d_c%0d_sclk", s, c), int'(SClk), m ? int'(lvl) : 0);
        rxc += int'(RxTick);
      end
      $display("random %0d: mode=%0d pol=%0d div=%0d frac=%0d expiries=%0d rx=%0d",
               s, m, p, d, f, nn - 1, rxc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
